prv_trap_sequencer: RTL and testbench
=====================================

// Module: prv_trap_sequencer
// PURPOSE
//  Machine-mode trap/return controller in the priv block. Prioritises exceptions from the
//  hazard unit and pending interrupts. Sequences the pipeline flush, then commits cause/epc/tval
//  to the CSR file, then redirects fetch via insert_pc/priv_pc. Also handles MRET.
// PARAMETERS
//  XLEN        32   datapath/word width
//  VECTORED_EN 1    1: honour mtvec.MODE=1 for interrupts; 0: always direct mode
// PORTS
//  CLK            in   1     clock, all state updates on rising edge
//  nRST           in   1     synchronous active-low reset
//  fault_insn, mal_insn, illegal_insn, breakpoint, env_m,
//  mal_l, fault_l, mal_s, fault_s   in 1 each   exception flags from hazard unit
//  ret            in   1     MRET at commit point
//  ext_int, soft_int, timer_int  in 1 each   pending AND per-bit mie-enabled interrupts
//  mstatus_mie    in   1     global interrupt enable
//  epc            in   XLEN  PC of faulting/interrupted instruction
//  badaddr        in   XLEN  faulting address (loads/stores/insn fetch)
//  mtvec          in   XLEN  trap vector; [1:0]=MODE, [XLEN-1:2]=BASE
//  mepc           in   XLEN  current mepc, MRET target
//  pipe_clear     in   1     pipeline drained/empty acknowledge
//  flush_req      out  1     request pipeline flush/hold
//  trap_commit    out  1     1-cycle pulse: CSR file writes mcause/mepc/mtval, stacks MIE
//  ret_commit     out  1     1-cycle pulse: CSR file restores MIE from MPIE
//  intr           out  1     latched: current trap is an interrupt (mcause[XLEN-1])
//  cause          out  4     latched mcause code
//  epc_out        out  XLEN  latched epc
//  tval           out  XLEN  latched mtval (0 where not address-related)
//  insert_pc      out  1     1-cycle pulse: fetch must load priv_pc
//  priv_pc        out  XLEN  redirect target, valid when insert_pc=1
//  busy           out  1     state != IDLE
// BEHAVIOUR
//  Reset (nRST=0 at edge): state=IDLE; all outputs 0, including latched cause/epc/tval/priv_pc.
//  Reset mid-sequence aborts with no commit and no redirect.
//  FSM states: IDLE -> FLUSH -> COMMIT -> REDIRECT -> IDLE.
//  IDLE: sample events each cycle. Priority: exception > interrupt > ret.
//   Exception priority/code: fault_insn 1, mal_insn 0, illegal_insn 2, breakpoint 3, env_m 11,
//   mal_l 4, fault_l 5, mal_s 6, fault_s 7.
//   Interrupts taken only if mstatus_mie=1. Priority/code: ext 11, soft 3, timer 7; intr=1.
//   tval = badaddr for codes 0,1,4,5,6,7; else 0.
//   On event: latch cause/intr/epc_out/tval and the target, then go to FLUSH.
//   Target:
//    - ret: target = mepc.
//    - Trap, direct mode: target = {BASE,2'b00}.
//    - Interrupt with MODE=1 and VECTORED_EN=1: target = {BASE,2'b00} + 4*cause.
//    - Addition is modulo 2^XLEN.
//  FLUSH: flush_req=1. Hold while pipe_clear=0. Go to COMMIT in the cycle after pipe_clear=1 is sampled.
//  COMMIT: flush_req=1. trap_commit=1 (trap) or ret_commit=1 (ret) for exactly one cycle.
//  REDIRECT: flush_req=1, insert_pc=1, priv_pc=target for exactly one cycle, then IDLE.
//  Minimum latency: event in IDLE at cycle N, pipe_clear=1 at N+1 -> commit N+2, insert_pc N+3.
//  Events arriving while busy are ignored; the hazard unit re-presents them after restart.
//  MODE values 2/3 are treated as direct.
//  Simultaneous exception + interrupt: the exception wins and the interrupt stays pending.
//  Simultaneous ret + exception: the exception wins.
//  Simultaneous ret + interrupt: the interrupt wins if enabled.
//  Latched outputs hold their values until the next event is accepted.
// TESTING
//  1 illegal_insn=1, epc=0x100, mtvec=0x8000_0000, pipe_clear=1
//    -> trap_commit@N+2 with cause=2, intr=0, tval=0; insert_pc@N+3 with priv_pc=0x8000_0000.
//  2 mal_l=1 and fault_l=1, badaddr=0x203
//    -> cause=4, tval=0x203; exactly one trap_commit pulse.
//  3 ext_int=timer_int=1, mie=1, mtvec=0x1001
//    -> intr=1, cause=11, priv_pc=0x102C. Same with mie=0 -> no action, busy=0.
//  4 ret=1, mepc=0x440, pipe_clear held 0 for 5 cycles
//    -> flush_req held high; ret_commit 1 cycle after pipe_clear rises; priv_pc=0x440.
//  5 env_m during FLUSH of a prior trap -> ignored, single commit.
//    nRST=0 during COMMIT -> next cycle all outputs 0, no insert_pc.
//  6 mtvec=0xFFFF_FFFD, soft_int -> priv_pc wraps to 0x0000_0008.

Source files
------------

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap/return sequencer: picks the winning exception, interrupt or MRET,
// drains the pipeline, pulses the CSR commit, then redirects fetch to the handler or mepc.
module prv_trap_sequencer #(
    parameter int unsigned XLEN        = 32,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            fault_insn,
    input  logic            mal_insn,
    input  logic            illegal_insn,
    input  logic            breakpoint,
    input  logic            env_m,
    input  logic            mal_l,
    input  logic            fault_l,
    input  logic            mal_s,
    input  logic            fault_s,
    input  logic            ret,
    input  logic            ext_int,
    input  logic            soft_int,
    input  logic            timer_int,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] badaddr,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            pipe_clear,
    output logic            flush_req,
    output logic            trap_commit,
    output logic            ret_commit,
    output logic            intr,
    output logic [3:0]      cause,
    output logic [XLEN-1:0] epc_out,
    output logic [XLEN-1:0] tval,
    output logic            insert_pc,
    output logic [XLEN-1:0] priv_pc,
    output logic            busy
);

    localparam int unsigned CAUSE_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t state, state_d;

    logic               is_ret_q, is_ret_d;
    logic               flush_req_d, trap_commit_d, ret_commit_d, insert_pc_d, busy_d;
    logic               intr_d;
    logic [CAUSE_W-1:0] cause_d;
    logic [XLEN-1:0]    epc_out_d, tval_d, priv_pc_d;

    logic               exc_any, irq_any, exc_addr;
    logic [CAUSE_W-1:0] exc_code, irq_code;
    logic [XLEN-1:0]    vec_base, irq_target;
    logic               use_vector;

    // Exception arbitration: fixed priority, plus whether mtval carries badaddr
    always_comb begin
        exc_code = '0;
        exc_addr = 1'b0;
        if (fault_insn) begin
            exc_code = CAUSE_W'(1);
            exc_addr = 1'b1;
        end else if (mal_insn) begin
            exc_code = CAUSE_W'(0);
            exc_addr = 1'b1;
        end else if (illegal_insn) begin
            exc_code = CAUSE_W'(2);
        end else if (breakpoint) begin
            exc_code = CAUSE_W'(3);
        end else if (env_m) begin
            exc_code = CAUSE_W'(11);
        end else if (mal_l) begin
            exc_code = CAUSE_W'(4);
            exc_addr = 1'b1;
        end else if (fault_l) begin
            exc_code = CAUSE_W'(5);
            exc_addr = 1'b1;
        end else if (mal_s) begin
            exc_code = CAUSE_W'(6);
            exc_addr = 1'b1;
        end else if (fault_s) begin
            exc_code = CAUSE_W'(7);
            exc_addr = 1'b1;
        end
    end

    assign exc_any = fault_insn | mal_insn | illegal_insn | breakpoint | env_m |
                     mal_l | fault_l | mal_s | fault_s;

    // Interrupt arbitration, gated by the global enable
    always_comb begin
        irq_code = CAUSE_W'(7);
        if (ext_int) begin
            irq_code = CAUSE_W'(11);
        end else if (soft_int) begin
            irq_code = CAUSE_W'(3);
        end
    end

    assign irq_any    = mstatus_mie & (ext_int | soft_int | timer_int);
    assign vec_base   = {mtvec[XLEN-1:2], 2'b00};
    assign use_vector = VECTORED_EN && (mtvec[1:0] == 2'b01);
    // Vector offset wraps naturally at XLEN bits
    assign irq_target = use_vector ? (vec_base + (XLEN'(irq_code) << 2)) : vec_base;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            is_ret_q    <= 1'b0;
            flush_req   <= 1'b0;
            trap_commit <= 1'b0;
            ret_commit  <= 1'b0;
            intr        <= 1'b0;
            cause       <= '0;
            epc_out     <= '0;
            tval        <= '0;
            insert_pc   <= 1'b0;
            priv_pc     <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            is_ret_q    <= is_ret_d;
            flush_req   <= flush_req_d;
            trap_commit <= trap_commit_d;
            ret_commit  <= ret_commit_d;
            intr        <= intr_d;
            cause       <= cause_d;
            epc_out     <= epc_out_d;
            tval        <= tval_d;
            insert_pc   <= insert_pc_d;
            priv_pc     <= priv_pc_d;
            busy        <= busy_d;
        end
    end

    // Next state, latched trap record, and registered control pulses
    always_comb begin
        state_d       = state;
        is_ret_d      = is_ret_q;
        intr_d        = intr;
        cause_d       = cause;
        epc_out_d     = epc_out;
        tval_d        = tval;
        priv_pc_d     = priv_pc;
        flush_req_d   = 1'b0;
        trap_commit_d = 1'b0;
        ret_commit_d  = 1'b0;
        insert_pc_d   = 1'b0;
        busy_d        = 1'b0;

        case (state)
            IDLE: begin
                if (exc_any) begin
                    state_d   = FLUSH;
                    is_ret_d  = 1'b0;
                    intr_d    = 1'b0;
                    cause_d   = exc_code;
                    epc_out_d = epc;
                    tval_d    = exc_addr ? badaddr : '0;
                    priv_pc_d = vec_base;
                end else if (irq_any) begin
                    state_d   = FLUSH;
                    is_ret_d  = 1'b0;
                    intr_d    = 1'b1;
                    cause_d   = irq_code;
                    epc_out_d = epc;
                    tval_d    = '0;
                    priv_pc_d = irq_target;
                end else if (ret) begin
                    state_d   = FLUSH;
                    is_ret_d  = 1'b1;
                    priv_pc_d = mepc;
                end
            end
            FLUSH: begin
                if (pipe_clear) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:   state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        busy_d        = (state_d != IDLE);
        flush_req_d   = busy_d;
        trap_commit_d = (state_d == COMMIT) && !is_ret_d;
        ret_commit_d  = (state_d == COMMIT) && is_ret_d;
        insert_pc_d   = (state_d == REDIRECT);
    end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Randomized bench for prv_trap_sequencer against a transaction-level trap model.
module tb_prv_trap_sequencer;

    localparam int unsigned XLEN = 32;

    logic            CLK;
    logic            nRST;
    logic            fault_insn, mal_insn, illegal_insn, breakpoint, env_m;
    logic            mal_l, fault_l, mal_s, fault_s;
    logic            ret, ext_int, soft_int, timer_int, mstatus_mie;
    logic [XLEN-1:0] epc, badaddr, mtvec, mepc;
    logic            pipe_clear;
    logic            flush_req, trap_commit, ret_commit, intr, insert_pc, busy;
    logic [3:0]      cause;
    logic [XLEN-1:0] epc_out, tval, priv_pc;

    int total;
    int bad;

    prv_trap_sequencer #(.XLEN(XLEN), .VECTORED_EN(1'b1)) dut (
        .CLK(CLK), .nRST(nRST),
        .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
        .breakpoint(breakpoint), .env_m(env_m), .mal_l(mal_l), .fault_l(fault_l),
        .mal_s(mal_s), .fault_s(fault_s), .ret(ret),
        .ext_int(ext_int), .soft_int(soft_int), .timer_int(timer_int),
        .mstatus_mie(mstatus_mie), .epc(epc), .badaddr(badaddr), .mtvec(mtvec),
        .mepc(mepc), .pipe_clear(pipe_clear),
        .flush_req(flush_req), .trap_commit(trap_commit), .ret_commit(ret_commit),
        .intr(intr), .cause(cause), .epc_out(epc_out), .tval(tval),
        .insert_pc(insert_pc), .priv_pc(priv_pc), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Exception bits: [0]fault_insn [1]mal_insn [2]illegal [3]breakpoint [4]env_m
    //                 [5]mal_l [6]fault_l [7]mal_s [8]fault_s; irq bits: [0]ext [1]soft [2]timer
    task automatic set_events(input logic [8:0] e, input logic [2:0] q, input logic m,
                              input logic r);
        {fault_s, mal_s, fault_l, mal_l, env_m, breakpoint, illegal_insn, mal_insn, fault_insn} = e;
        {timer_int, soft_int, ext_int} = q;
        mstatus_mie = m;
        ret = r;
    endtask

    // Reference: list-ordered priority search, mtvec arithmetic on 64-bit integers
    function automatic void model(input logic [8:0] e, input logic [2:0] q, input logic m,
                                  input logic r, input logic [31:0] ba, input logic [31:0] tv,
                                  input logic [31:0] me, output bit taken, output bit is_r,
                                  output bit ei, output int ec, output logic [31:0] etval,
                                  output logic [31:0] etgt);
        int exc_codes[9] = '{1, 0, 2, 3, 11, 4, 5, 6, 7};
        bit addr_rel[9]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
        int irq_codes[3] = '{11, 3, 7};
        longint unsigned base;
        base  = longint'(tv) - (longint'(tv) % 4);
        taken = 0; is_r = 0; ei = 0; ec = 0; etval = 0; etgt = 0;
        for (int i = 0; i < 9; i++) begin
            if (e[i] && !taken) begin
                taken = 1;
                ec    = exc_codes[i];
                etval = addr_rel[i] ? ba : 32'h0;
                etgt  = 32'(base);
            end
        end
        if (!taken && m) begin
            for (int i = 0; i < 3; i++) begin
                if (q[i] && !taken) begin
                    taken = 1;
                    ei    = 1;
                    ec    = irq_codes[i];
                    if (tv % 4 == 1) etgt = 32'((base + 4 * longint'(ec)) % 64'h1_0000_0000);
                    else             etgt = 32'(base);
                end
            end
        end
        if (!taken && r) begin
            taken = 1;
            is_r  = 1;
            etgt  = me;
        end
    endfunction

    task automatic run_txn(input logic [8:0] e, input logic [2:0] q, input logic m,
                           input logic r, input logic [31:0] ep, input logic [31:0] ba,
                           input logic [31:0] tv, input logic [31:0] me, input int delay,
                           input bit junk);
        bit taken, is_r, ei;
        int ec;
        logic [31:0] etval, etgt;
        model(e, q, m, r, ba, tv, me, taken, is_r, ei, ec, etval, etgt);
        set_events(e, q, m, r);
        epc = ep; badaddr = ba; mtvec = tv; mepc = me;
        pipe_clear = 1'($urandom);
        tick();
        set_events('0, '0, 1'b0, 1'b0);
        pipe_clear = 1'b0;
        if (!taken) begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_flush", 32'(flush_req), 32'd0);
            return;
        end
        chk("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i <= delay; i++) begin
            // Events and operand churn while busy must not disturb the latched record
            if (junk) begin
                set_events(9'($urandom) | 9'h010, 3'($urandom), 1'b1, 1'($urandom));
                epc = $urandom; badaddr = $urandom; mtvec = $urandom; mepc = $urandom;
            end
            chk("flush_held", 32'(flush_req), 32'd1);
            chk("early_commit", 32'({trap_commit, ret_commit, insert_pc}), 32'd0);
            if (i == delay) pipe_clear = 1'b1;
            tick();
        end
        set_events('0, '0, 1'b0, 1'b0);
        pipe_clear = 1'($urandom);
        chk("trap_commit", 32'(trap_commit), 32'(!is_r));
        chk("ret_commit", 32'(ret_commit), 32'(is_r));
        chk("commit_flush", 32'(flush_req), 32'd1);
        chk("commit_nopc", 32'(insert_pc), 32'd0);
        if (!is_r) begin
            chk("cause", 32'(cause), 32'(ec));
            chk("intr", 32'(intr), 32'(ei));
            chk("epc_out", epc_out, ep);
            chk("tval", tval, etval);
        end
        tick();
        chk("insert_pc", 32'(insert_pc), 32'd1);
        chk("priv_pc", priv_pc, etgt);
        chk("one_commit", 32'({trap_commit, ret_commit}), 32'd0);
        chk("redir_flush", 32'(flush_req), 32'd1);
        tick();
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_pc", 32'(insert_pc), 32'd0);
        if (!is_r) begin
            chk("cause_hold", 32'(cause), 32'(ec));
            chk("tval_hold", tval, etval);
        end
        pipe_clear = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({flush_req, trap_commit, ret_commit, intr, insert_pc, busy}), 32'd0);
        chk({tag, "_cause"}, 32'(cause), 32'd0);
        chk({tag, "_epc"}, epc_out, 32'd0);
        chk({tag, "_tval"}, tval, 32'd0);
        chk({tag, "_pc"}, priv_pc, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nRST  = 1'b0;
        set_events('0, '0, 1'b0, 1'b0);
        epc = '0; badaddr = '0; mtvec = '0; mepc = '0; pipe_clear = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        nRST = 1'b1;
        tick();

        // Directed scenarios
        run_txn(9'h004, 3'b000, 1'b0, 1'b0, 32'h100, 32'h1234, 32'h8000_0000, 32'h0, 0, 0);
        run_txn(9'h060, 3'b000, 1'b0, 1'b0, 32'h300, 32'h203, 32'h8000_0000, 32'h0, 0, 0);
        run_txn(9'h000, 3'b101, 1'b1, 1'b0, 32'h500, 32'h77, 32'h1001, 32'h0, 1, 0);
        run_txn(9'h000, 3'b101, 1'b0, 1'b0, 32'h500, 32'h77, 32'h1001, 32'h0, 1, 0);
        tick();
        chk("mie_off_busy", 32'(busy), 32'd0);
        run_txn(9'h000, 3'b000, 1'b0, 1'b1, 32'h600, 32'h0, 32'h1001, 32'h440, 5, 0);
        run_txn(9'h004, 3'b000, 1'b0, 1'b0, 32'h700, 32'h0, 32'h2000, 32'h0, 3, 1);
        run_txn(9'h000, 3'b010, 1'b1, 1'b0, 32'h800, 32'h0, 32'hFFFF_FFFD, 32'h0, 0, 0);
        run_txn(9'h100, 3'b111, 1'b1, 1'b1, 32'h900, 32'hABC, 32'h4001, 32'h40, 2, 0);
        run_txn(9'h000, 3'b100, 1'b1, 1'b1, 32'hA00, 32'h0, 32'h4001, 32'h40, 1, 0);
        run_txn(9'h000, 3'b100, 1'b1, 1'b0, 32'hB00, 32'h0, 32'h4002, 32'h40, 0, 0);

        // Reset while the commit pulse is up: no redirect may follow
        set_events(9'h008, '0, 1'b0, 1'b0);
        epc = 32'hC00; mtvec = 32'h3000;
        tick();
        set_events('0, '0, 1'b0, 1'b0);
        pipe_clear = 1'b1;
        tick();
        pipe_clear = 1'b0;
        chk("rst_pre_commit", 32'(trap_commit), 32'd1);
        nRST = 1'b0;
        tick();
        chk_all_zero("rst_mid");
        nRST = 1'b1;
        tick();
        chk("rst_no_pc", 32'(insert_pc), 32'd0);
        chk("rst_idle", 32'(busy), 32'd0);

        // Randomized traffic, sparse events so each kind wins regularly
        for (int n = 0; n < 300; n++) begin
            logic [8:0] e;
            logic [2:0] q;
            e = 9'($urandom) & 9'($urandom) & 9'($urandom) & 9'($urandom);
            q = 3'($urandom) & 3'($urandom);
            run_txn(e, q, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                    $urandom, int'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
